jts16_obj_dbuf: RTL



---
 rtl/jts16_obj_pkg.sv | 13 +
 rtl/jtframe_dual_ram16.sv | 31 +++
 rtl/jts16_obj_copy.sv | 78 +++++++
 rtl/jts16_obj_dbuf.sv | 90 +++++++++
 4 files changed

// File: rtl/jts16_obj_pkg.sv
// rtl/jts16_obj_pkg.sv - shared types and constants for the object RAM double buffer
package jts16_obj_pkg;

   localparam int OBJ_DW = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_COPY,
      ST_FLUSH
   } obj_state_e;

endpackage

// File: rtl/jtframe_dual_ram16.sv
// rtl/jtframe_dual_ram16.sv - single-clock true dual-port 16-bit RAM with byte enables
module jtframe_dual_ram16
   import jts16_obj_pkg::*;
#(
   parameter int AW = 11
) (
   input  logic              clk,
   input  logic [AW-1:0]     addr0,
   input  logic [OBJ_DW-1:0] data0,
   input  logic [1:0]        we0,
   output logic [OBJ_DW-1:0] q0,
   input  logic [AW-1:0]     addr1,
   input  logic [OBJ_DW-1:0] data1,
   input  logic [1:0]        we1,
   output logic [OBJ_DW-1:0] q1
);

   logic [7:0] mem_hi [0:2**AW-1];
   logic [7:0] mem_lo [0:2**AW-1];

   // Reads return the word as it was before any write on the same edge.
   always_ff @(posedge clk) begin
      q0 <= {mem_hi[addr0], mem_lo[addr0]};
      q1 <= {mem_hi[addr1], mem_lo[addr1]};
      if (we0[0]) mem_lo[addr0] <= data0[7:0];
      if (we0[1]) mem_hi[addr0] <= data0[15:8];
      if (we1[0]) mem_lo[addr1] <= data1[7:0];
      if (we1[1]) mem_hi[addr1] <= data1[15:8];
   end

endmodule

// File: rtl/jts16_obj_copy.sv
// rtl/jts16_obj_copy.sv - swap request FSM and front-to-back copy sequencer
module jts16_obj_copy
   import jts16_obj_pkg::*;
#(
   parameter int AW      = 11,
   parameter int VB_SYNC = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          swap,
   input  logic          vblank,
   output logic [AW-1:0] rd_addr,
   output logic [AW-1:0] wr_addr,
   output logic          wr_en,
   output logic          copying,
   output logic          busy,
   output logic          done
);

   obj_state_e  state, state_nx;
   logic [AW:0] cnt, cnt_inc;
   logic        pending, vb_last, vb_rise, start;

   assign cnt_inc = cnt + 1'b1;
   assign vb_rise = vblank & ~vb_last;
   assign start   = (VB_SYNC != 0) ? vb_rise : 1'b1;
   assign rd_addr = cnt[AW-1:0];
   assign copying = (state == ST_COPY) || (state == ST_FLUSH);

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (swap) state_nx = ST_ARMED;
         end
         ST_ARMED: begin
            busy = 1'b1;
            if (start) state_nx = ST_COPY;
         end
         ST_COPY: begin
            busy = 1'b1;
            // MSB of the incremented count means the last read is going out now
            if (cnt_inc[AW]) state_nx = ST_FLUSH;
         end
         ST_FLUSH: begin
            done     = 1'b1;
            busy     = pending | swap;
            state_nx = (pending | swap) ? ST_ARMED : ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         pending <= 1'b0;
         vb_last <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
      end else begin
         state   <= state_nx;
         vb_last <= vblank;
         cnt     <= (state == ST_COPY) ? cnt_inc : '0;
         // Write trails the read by one cycle to meet the RAM read latency
         wr_en   <= (state == ST_COPY);
         wr_addr <= cnt[AW-1:0];
         if (state == ST_FLUSH)
            pending <= 1'b0;
         else if (swap && state == ST_COPY)
            pending <= 1'b1;
      end
   end

endmodule

// File: rtl/jts16_obj_dbuf.sv
// rtl/jts16_obj_dbuf.sv - object RAM with optional hardware double buffer
module jts16_obj_dbuf
   import jts16_obj_pkg::*;
#(
   parameter int AW      = 11,
   parameter int DBUF    = 1,
   parameter int VB_SYNC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              obj_cs,
   input  logic [AW-1:0]     cpu_addr,
   input  logic [OBJ_DW-1:0] cpu_dout,
   input  logic [1:0]        dsn,
   output logic [OBJ_DW-1:0] cpu_din,
   input  logic              swap,
   input  logic              vblank,
   input  logic [AW-1:0]     tbl_addr,
   input  logic              tbl_we,
   input  logic [OBJ_DW-1:0] tbl_din,
   output logic [OBJ_DW-1:0] tbl_dout,
   output logic              busy,
   output logic              done
);

   logic [1:0] cpu_we;
   assign cpu_we = ~dsn & {2{obj_cs}};

   generate
      if (DBUF != 0) begin : g_dbuf
         logic [AW-1:0]     rd_addr, wr_addr;
         logic              wr_en, copying;
         logic [OBJ_DW-1:0] front_q1;

         jtframe_dual_ram16 #(.AW(AW)) u_front (
            .clk   (clk),
            .addr0 (cpu_addr),
            .data0 (cpu_dout),
            .we0   (cpu_we),
            .q0    (cpu_din),
            .addr1 (rd_addr),
            .data1 ('0),
            .we1   (2'b00),
            .q1    (front_q1)
         );

         // Scanner writes are dropped while the copy owns the back table
         jtframe_dual_ram16 #(.AW(AW)) u_back (
            .clk   (clk),
            .addr0 (wr_addr),
            .data0 (front_q1),
            .we0   ({2{wr_en}}),
            .q0    (),
            .addr1 (tbl_addr),
            .data1 (tbl_din),
            .we1   ({2{tbl_we & ~copying}}),
            .q1    (tbl_dout)
         );

         jts16_obj_copy #(.AW(AW), .VB_SYNC(VB_SYNC)) u_copy (
            .clk     (clk),
            .rst_n   (rst_n),
            .swap    (swap),
            .vblank  (vblank),
            .rd_addr (rd_addr),
            .wr_addr (wr_addr),
            .wr_en   (wr_en),
            .copying (copying),
            .busy    (busy),
            .done    (done)
         );
      end else begin : g_single
         jtframe_dual_ram16 #(.AW(AW)) u_front (
            .clk   (clk),
            .addr0 (cpu_addr),
            .data0 (cpu_dout),
            .we0   (cpu_we),
            .q0    (cpu_din),
            .addr1 (tbl_addr),
            .data1 (tbl_din),
            .we1   ({2{tbl_we}}),
            .q1    (tbl_dout)
         );

         assign busy = 1'b0;
         assign done = 1'b0;
      end
   endgenerate

endmodule
